// File: rtl/writeback_regfile.sv
// Purpose : Y86-64 write-back stage and architectural register file with RUN/HLT/INS status FSM.
// Latency : register reads are combinational; a write committing this cycle is bypassed to the read ports.
// Backpressure: none; a retiring instruction is accepted whenever wb_valid is high, and ignored after a halt.
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   wb_valid, iCode, rA, rB, cnd  retiring instruction fields from the memory stage
//   valE, valM                    ALU result and memory read result
//   srcA, srcB                    decode-stage read addresses (4'hF = none, reads 0)
//   reg_stackA/B, reg_stack4      read data for srcA, srcB and %rsp
//   status, halted, retired       architectural status, halt flag, committed-instruction count
module writeback_regfile #(
  parameter int               REG_W      = 64,
  parameter logic [REG_W-1:0] STACK_INIT = 64'h0000_0000_0000_0200,
  parameter int               CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [3:0]       iCode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             cnd,
  input  logic [REG_W-1:0] valE,
  input  logic [REG_W-1:0] valM,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  output logic [REG_W-1:0] reg_stackA,
  output logic [REG_W-1:0] reg_stackB,
  output logic [REG_W-1:0] reg_stack4,
  output logic [1:0]       status,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  // State encoding doubles as the architectural status code.
  typedef enum logic [1:0] {
    S_RUN = 2'b00,
    S_HLT = 2'b01,
    S_INS = 2'b10
  } state_t;

  state_t           state;
  logic [REG_W-1:0] regs [0:14];

  logic       commit;
  logic [3:0] dst_e;
  logic [3:0] dst_m;
  logic       we_e;
  logic       we_m;

  // A valid instruction retiring in RUN; the halt instruction counts, an illegal one does not.
  assign commit = wb_valid && (state == S_RUN) && (iCode <= 4'hB);

  always_comb begin
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    if (commit) begin
      case (iCode)
        4'h2:             if (cnd) dst_e = rB;
        4'h3, 4'h6:       dst_e = rB;
        4'h5:             dst_m = rA;
        4'h8, 4'h9, 4'hA: dst_e = REG_RSP;
        4'hB: begin
          dst_e = REG_RSP;
          dst_m = rA;
        end
        default: ;
      endcase
    end
  end

  // popq %rsp targets reg 4 through both ports; the loaded value must win.
  assign we_m = (dst_m != REG_NONE);
  assign we_e = (dst_e != REG_NONE) && (dst_e != dst_m);

  // Same priority as the commit: valM before valE, otherwise the stored value.
  function automatic logic [REG_W-1:0] fwd(
    input logic [3:0]       addr,
    input logic [REG_W-1:0] stored,
    input logic             wm,
    input logic [3:0]       dm,
    input logic [REG_W-1:0] vm,
    input logic             wen,
    input logic [3:0]       de,
    input logic [REG_W-1:0] ve
  );
    if (addr == REG_NONE)         return '0;
    else if (wm && (dm == addr))  return vm;
    else if (wen && (de == addr)) return ve;
    else                          return stored;
  endfunction

  logic [REG_W-1:0] stored_a;
  logic [REG_W-1:0] stored_b;

  assign stored_a = (srcA == REG_NONE) ? '0 : regs[srcA];
  assign stored_b = (srcB == REG_NONE) ? '0 : regs[srcB];

  assign reg_stackA = fwd(srcA, stored_a, we_m, dst_m, valM, we_e, dst_e, valE);
  assign reg_stackB = fwd(srcB, stored_b, we_m, dst_m, valM, we_e, dst_e, valE);
  assign reg_stack4 = fwd(REG_RSP, regs[4], we_m, dst_m, valM, we_e, dst_e, valE);

  assign status = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == 4) ? STACK_INIT : '0;
      end
      state   <= S_RUN;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      if (we_e) regs[dst_e] <= valE;
      if (we_m) regs[dst_m] <= valM;
      if (wb_valid && (state == S_RUN)) begin
        if (iCode == 4'h0) begin
          state  <= S_HLT;
          halted <= 1'b1;
        end else if (iCode > 4'hB) begin
          state  <= S_INS;
          halted <= 1'b1;
        end
      end
      if (commit) retired <= retired + 1'b1;
    end
  end

endmodule
